// File: rtl/ula_seq_16_bits.sv
// ula_seq_16_bits
// Runs a 16-bit ALU operation as two passes through one shared 8-bit ALU
// (ula_8_bits): low byte first, then high byte. Carry is chained between
// passes, with the ALU's per-function carry polarity folded back to a true
// carry. Result and flags are registered, and completion is a one-cycle pulse.
module ula_seq_16_bits (
    input  logic        clk,
    input  logic        rst,

    // command side
    input  logic        start,
    output logic        ready,
    input  logic        op_m,
    input  logic [3:0]  op_s,
    input  logic        op_cin,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,

    // registered response
    output logic [15:0] result,
    output logic        c_out,
    output logic        overflow,
    output logic        a_eq_b,
    output logic        done,

    // shared 8-bit ALU
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_s,
    output logic        alu_m,
    output logic        alu_c_in,
    input  logic [7:0]  alu_f,
    input  logic        alu_c_out,
    input  logic        alu_a_eq_b
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Arithmetic function codes that need special handling.
    localparam logic [3:0] S_ADD = 4'b1001;   // A plus B
    localparam logic [3:0] S_SUB = 4'b0110;   // A minus B minus 1 (cin adds 1)

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched command; only these copies are used once the op is accepted.
    logic        r_m;
    logic [3:0]  r_s;
    logic        r_cin;
    logic [15:0] r_a;
    logic [15:0] r_b;

    // Low-pass intermediate results carried into the high pass.
    logic        r_carry;
    logic        r_eq_lo;

    // Registered response.
    logic [15:0] r_result;
    logic        r_c_out;
    logic        r_ovf;
    logic        r_a_eq_b;

    logic        w_accept;

    // These ALU functions report an inverted (borrow-style) carry-out.
    function automatic logic carry_is_complemented(input logic [3:0] s);
        case (s)
            4'b0000, 4'b0010, 4'b0011,
            4'b0110, 4'b0111, 4'b1011: carry_is_complemented = 1'b1;
            default:                   carry_is_complemented = 1'b0;
        endcase
    endfunction

    // Converts the ALU low-pass carry-out into the active-high carry-in for
    // the high pass. Logic mode has no carry to chain.
    function automatic logic chain_carry(input logic       m,
                                         input logic [3:0] s,
                                         input logic       cout);
        if (m)
            chain_carry = 1'b0;
        else if (carry_is_complemented(s))
            chain_carry = ~cout;
        else
            chain_carry = cout;
    endfunction

    // Two's-complement overflow for add and subtract, from the sign bits of
    // the operands and of the high-pass result.
    function automatic logic signed_overflow(input logic       m,
                                             input logic [3:0] s,
                                             input logic       a15,
                                             input logic       b15,
                                             input logic       f15);
        if (m)
            signed_overflow = 1'b0;
        else if (s == S_ADD)
            signed_overflow = (a15 == b15) && (f15 != a15);
        else if (s == S_SUB)
            signed_overflow = (a15 != b15) && (f15 == b15);
        else
            signed_overflow = 1'b0;
    endfunction

    assign w_accept = (r_state == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state, handshake outputs and ALU drive for the current pass.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_s       = 4'h0;
        alu_m       = 1'b0;
        alu_c_in    = 1'b0;

        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start)
                    w_state_nxt = S_LO;
            end
            S_LO: begin
                alu_a       = r_a[7:0];
                alu_b       = r_b[7:0];
                alu_s       = r_s;
                alu_m       = r_m;
                alu_c_in    = r_cin;
                w_state_nxt = S_HI;
            end
            S_HI: begin
                alu_a       = r_a[15:8];
                alu_b       = r_b[15:8];
                alu_s       = r_s;
                alu_m       = r_m;
                alu_c_in    = r_carry;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch; operand inputs are free to change after acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_m   <= op_m;
            r_s   <= op_s;
            r_cin <= op_cin;
            r_a   <= op_a;
            r_b   <= op_b;
        end
    end

    // Low-pass capture of chained carry and byte-equality flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_eq_lo <= 1'b0;
        end else if (r_state == S_LO) begin
            r_carry <= chain_carry(r_m, r_s, alu_c_out);
            r_eq_lo <= alu_a_eq_b;
        end
    end

    // Result and flags: low byte lands after LO, everything else after HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 16'h0000;
            r_c_out  <= 1'b0;
            r_ovf    <= 1'b0;
            r_a_eq_b <= 1'b0;
        end else begin
            if (r_state == S_LO)
                r_result[7:0] <= alu_f;
            if (r_state == S_HI) begin
                r_result[15:8] <= alu_f;
                r_c_out        <= r_m ? 1'b0 : alu_c_out;
                r_ovf          <= signed_overflow(r_m, r_s, r_a[15], r_b[15], alu_f[7]);
                r_a_eq_b       <= r_eq_lo & alu_a_eq_b;
            end
        end
    end

    assign result   = r_result;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;
    assign a_eq_b   = r_a_eq_b;

endmodule

// File: tb/tb_ula_seq_16_bits.sv
// Bench for ula_seq_16_bits: a behavioural 8-bit ALU model sits on the ALU
// port, directed operations push their hand-computed response into a queue,
// and a monitor pops and compares on every done pulse.
module tb_ula_seq_16_bits;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ready;
    logic        op_m;
    logic [3:0]  op_s;
    logic        op_cin;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] result;
    logic        c_out;
    logic        overflow;
    logic        a_eq_b;
    logic        done;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic        alu_c_in;
    logic [7:0]  alu_f;
    logic        alu_c_out;
    logic        alu_a_eq_b;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        eq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    ula_seq_16_bits dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .op_m       (op_m),
        .op_s       (op_s),
        .op_cin     (op_cin),
        .op_a       (op_a),
        .op_b       (op_b),
        .result     (result),
        .c_out      (c_out),
        .overflow   (overflow),
        .a_eq_b     (a_eq_b),
        .done       (done),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_c_in   (alu_c_in),
        .alu_f      (alu_f),
        .alu_c_out  (alu_c_out),
        .alu_a_eq_b (alu_a_eq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74181-style 8-bit ALU with active-high carry-in; some arithmetic
    // functions report an inverted carry-out.
    logic [7:0] mx, my;
    logic [8:0] msum;
    always_comb begin
        mx = 8'h00;
        my = 8'h00;
        case (alu_s)
            4'h0: begin mx = alu_a;          my = 8'h00;          end
            4'h1: begin mx = alu_a | alu_b;  my = 8'h00;          end
            4'h2: begin mx = alu_a | ~alu_b; my = 8'h00;          end
            4'h3: begin mx = 8'h00;          my = 8'hFF;          end
            4'h4: begin mx = alu_a;          my = alu_a & ~alu_b; end
            4'h5: begin mx = alu_a | alu_b;  my = alu_a & ~alu_b; end
            4'h6: begin mx = alu_a;          my = ~alu_b;         end
            4'h7: begin mx = alu_a & ~alu_b; my = 8'hFF;          end
            4'h8: begin mx = alu_a;          my = alu_a & alu_b;  end
            4'h9: begin mx = alu_a;          my = alu_b;          end
            4'hA: begin mx = alu_a | ~alu_b; my = alu_a & alu_b;  end
            4'hB: begin mx = alu_a & alu_b;  my = 8'hFF;          end
            4'hC: begin mx = alu_a;          my = alu_a;          end
            4'hD: begin mx = alu_a | alu_b;  my = alu_a;          end
            4'hE: begin mx = alu_a | ~alu_b; my = alu_a;          end
            default: begin mx = alu_a;       my = 8'hFF;          end
        endcase
        msum = {1'b0, mx} + {1'b0, my} + {8'h00, alu_c_in};
        alu_f      = msum[7:0];
        alu_c_out  = msum[8];
        if (alu_s inside {4'h0, 4'h2, 4'h3, 4'h6, 4'h7, 4'hB})
            alu_c_out = ~msum[8];
        if (alu_m) begin
            alu_c_out = 1'b0;
            case (alu_s)
                4'h0: alu_f = ~alu_a;
                4'h1: alu_f = ~(alu_a | alu_b);
                4'h2: alu_f = ~alu_a & alu_b;
                4'h3: alu_f = 8'h00;
                4'h4: alu_f = ~(alu_a & alu_b);
                4'h5: alu_f = ~alu_b;
                4'h6: alu_f = alu_a ^ alu_b;
                4'h7: alu_f = alu_a & ~alu_b;
                4'h8: alu_f = ~alu_a | alu_b;
                4'h9: alu_f = ~(alu_a ^ alu_b);
                4'hA: alu_f = alu_b;
                4'hB: alu_f = alu_a & alu_b;
                4'hC: alu_f = 8'hFF;
                4'hD: alu_f = alu_a | ~alu_b;
                4'hE: alu_f = alu_a | alu_b;
                default: alu_f = alu_a;
            endcase
        end
        alu_a_eq_b = (alu_a == alu_b);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got result %0h want no pulse", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result",   result,   e.res);
                chk("c_out",    c_out,    e.c);
                chk("overflow", overflow, e.v);
                chk("a_eq_b",   a_eq_b,   e.eq);
            end
        end
    end

    // Issue one op, scramble the inputs after acceptance, and check the ALU
    // drive of each pass plus done/ready timing.
    task automatic do_op(input logic m, input logic [3:0] s, input logic cin,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic c, input logic v,
                         input logic eq, input logic hcin);
        int k;
        exp_t e;
        k = 0;
        while (!ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", ready, 1);
        if (!ready) return;
        op_m = m; op_s = s; op_cin = cin; op_a = a; op_b = b;
        start = 1'b1;
        e.res = res; e.c = c; e.v = v; e.eq = eq;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        op_m = ~m; op_s = ~s; op_cin = ~cin; op_a = ~a; op_b = ~b;
        chk("lo_alu_a",    alu_a,    a[7:0]);
        chk("lo_alu_b",    alu_b,    b[7:0]);
        chk("lo_alu_c_in", alu_c_in, cin);
        chk("lo_done",     done,     0);
        @(posedge clk); #1;
        chk("hi_alu_a",    alu_a,    a[15:8]);
        chk("hi_alu_c_in", alu_c_in, hcin);
        chk("hi_done",     done,     0);
        @(posedge clk); #1;
        chk("done_pulse",  done,     1);
        chk("done_ready",  ready,    0);
        chk("done_alu_s",  alu_s,    0);
        @(posedge clk); #1;
        chk("after_ready", ready,    1);
        chk("after_done",  done,     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        int   n0;
        bit   changed;
        exp_t e;

        rst = 1'b1; start = 1'b0; op_m = 1'b0; op_s = 4'h0; op_cin = 1'b0;
        op_a = 16'h0000; op_b = 16'h0000;
        #2;
        chk("rst_ready",    ready,    1);
        chk("rst_done",     done,     0);
        chk("rst_result",   result,   16'h0000);
        chk("rst_flags",    {c_out, overflow, a_eq_b}, 0);
        chk("rst_alu",      {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        //     m     s      cin   a         b         result    c     v     eq    hi_cin
        do_op(1'b0, 4'h9, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(1'b0, 4'h9, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op(1'b0, 4'h6, 1'b1, 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(1'b1, 4'h6, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 4'h9, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op(1'b0, 4'h6, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(1'b0, 4'h9, 1'b0, 16'h1111, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: start held high; first op accepted at once, then the
        // following window accepts exactly two ops, 4 cycles apart.
        op_m = 1'b0; op_s = 4'h9; op_cin = 1'b0; op_a = 16'h1111; op_b = 16'h1111;
        start = 1'b1;
        e.res = 16'h2222; e.c = 1'b0; e.v = 1'b0; e.eq = 1'b1; q.push_back(e);
        e.res = 16'h0007; e.c = 1'b0; e.v = 1'b0; e.eq = 1'b0; q.push_back(e);
        e.res = 16'h5559; e.c = 1'b0; e.v = 1'b0; e.eq = 1'b0; q.push_back(e);
        @(posedge clk); #1;
        op_a = 16'h0003; op_b = 16'h0004;
        n0 = n_done; acc = 0; changed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) acc++;
            else if (acc == 1 && !changed) begin
                op_a = 16'h5555;
                changed = 1'b1;
            end
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("b2b_accepts", acc, 2);
        chk("b2b_dones",   n_done - n0, 3);
        chk("b2b_ready",   ready, 1);

        // Reset while in HI: in-flight op is discarded with no done pulse.
        op_m = 1'b0; op_s = 4'h9; op_cin = 1'b0; op_a = 16'h1234; op_b = 16'h1111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_lo_byte", result[7:0], 8'h45);
        n0 = n_done;
        rst = 1'b1;
        #1;
        chk("mid_rst_result", result,   16'h0000);
        chk("mid_rst_ready",  ready,    1);
        chk("mid_rst_done",   done,     0);
        chk("mid_rst_alu",    {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_no_done", n_done - n0, 0);
        chk("post_rst_result",  result, 16'h0000);
        do_op(1'b0, 4'h9, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_seq_16_bits.md
# ula_seq_16_bits

Multi-cycle controller that performs 16-bit ALU operations by sequencing one external `ula_8_bits` instance through two 8-bit passes: low byte first, then high byte. It latches a command, drives the ALU's operand and function inputs each pass, and chains the carry between passes using the ALU's per-function carry polarity. It registers the 16-bit result and flags and signals completion with a one-cycle pulse. It sits between a command source (register file / microsequencer) and the shared 8-bit ALU.

## Interface
- Parameters: none (word width fixed at 16, ALU slice at 8).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: command valid; accepted only when `ready`=1.
- `ready` out 1: high in IDLE; decoded from state.
- `op_m` in 1: mode (0 = arithmetic, 1 = logic).
- `op_s` in 4: function select, same encoding as `ula_8_bits`.
- `op_cin` in 1: carry-in for the low pass (active-high: adds 1).
- `op_a`, `op_b` in 16: operands.
- `result` out 16: registered result, held until the next completion.
- `c_out` out 1: registered carry-out of the high pass, in ALU polarity.
- `overflow` out 1: registered signed overflow.
- `a_eq_b` out 1: registered AND of both passes' ALU `a_eq_b`.
- `done` out 1: one-cycle completion pulse.
- `alu_a`, `alu_b` out 8: ALU operand bytes.
- `alu_s` out 4, `alu_m` out 1, `alu_c_in` out 1: ALU controls.
- `alu_f` in 8, `alu_c_out` in 1, `alu_a_eq_b` in 1: ALU outputs (combinational, valid in the same cycle).

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE:
  - `ready`=1.
  - On `start`=1, latch `op_*` into internal registers and go to LO.
  - `start` outside IDLE is ignored; no queueing.
- LO:
  - Drive `alu_a`/`alu_b` = latched a[7:0]/b[7:0], `alu_s`/`alu_m` = latched, `alu_c_in` = latched `op_cin`.
  - At the clock edge, capture `alu_f` into `result[7:0]`, capture `alu_a_eq_b`, and compute the chained carry. Go to HI.
- Chained carry:
  - Complemented-carry functions (s ∈ {0000, 0010, 0011, 0110, 0111, 1011}): carry = ~`alu_c_out`.
  - All other s: carry = `alu_c_out`.
  - In logic mode (m=1), carry = 0.
- HI:
  - Drive the high bytes, same s/m, `alu_c_in` = chained carry.
  - At the clock edge, capture `result[15:8]` = `alu_f`.
  - `c_out` = `alu_c_out` when m=0, else 0.
  - `a_eq_b` = LO flag AND `alu_a_eq_b`.
  - Go to DONE.
- Overflow, computed from latched a[15], b[15] and `alu_f[7]`:
  - s=1001, m=0: (a15==b15) && (f15!=a15).
  - s=0110, m=0: (a15!=b15) && (f15==b15).
  - Otherwise 0.
- DONE: `done`=1, `ready`=0. Go to IDLE.
- In IDLE and DONE, all `alu_*` outputs are 0.
- Outputs update only at the HI→DONE edge, except `result[7:0]`, which updates at LO→HI.
  - Consequence: a new op visibly alters `result[7:0]` one cycle before `done`.
  - Consumers must sample outputs only when `done`=1.

## Timing
- Reset values:
  - State = IDLE, so `ready`=1.
  - `done`=0; `result`=0x0000; `c_out`=0; `overflow`=0; `a_eq_b`=0.
  - All `alu_*` outputs = 0.
- Latency: `start` sampled at edge N → LO in cycle N+1, HI in N+2, `done`=1 in N+3, `ready`=1 in N+4.
- Throughput: one operation per 4 cycles. With `start` held high, operations are accepted at N, N+4, N+8, ...
- Reset mid-operation: immediate return to reset values. No `done` pulse; the in-flight operation is discarded.
- Operand inputs may change freely after acceptance; only latched copies are used.

## Test plan
- Carry chain: m=0, s=1001, cin=0, a=0x00FF, b=0x0001.
  - `alu_c_in`=1 during HI.
  - result=0x0100, c_out=0, overflow=0.
  - `done` exactly 3 cycles after the accepting edge.
- Signed overflow: m=0, s=1001, cin=0, a=0x7FFF, b=0x0001 → result=0x8000, c_out=0, overflow=1.
- Subtract with complemented carry: m=0, s=0110, cin=1, a=0x1234, b=0x0234.
  - LO: ALU `alu_c_out`=0, so chained carry=1.
  - result=0x1000, c_out=0, overflow=0.
- Logic mode: m=1, s=0110, a=0xF0F0, b=0xFF00.
  - result=0x0FF0, c_out=0, overflow=0.
  - `alu_c_in`=0 during HI.
- Back-to-back and ignore: hold `start` high for 10 cycles.
  - Exactly two operations are accepted, 4 cycles apart.
  - `done` pulses once per operation.
  - Changing `op_a` mid-operation does not affect `result`.
- Reset mid-operation: assert `rst` during HI.
  - No `done` pulse; result=0x0000; `ready`=1 one cycle after `rst` deasserts.
  - A new op (a=0x0001, b=0x0001, s=1001) then completes normally with result=0x0002.
